usb_upload_arbiter: RTL



---
 rtl/usb_upload_pkg.sv | 11 +
 rtl/rr_arbiter_pick.sv | 25 ++
 rtl/usb_upload_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/usb_upload_pkg.sv
// usb_upload_pkg: shared FSM encoding, sync byte and source IDs for the USB upload path
package usb_upload_pkg;
    typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAYLOAD} state_t;
    typedef enum logic [1:0] {
        SRC_ID_LA   = 2'd0,
        SRC_ID_UART = 2'd1,
        SRC_ID_CMD  = 2'd2,
        SRC_ID_STAT = 2'd3
    } src_id_t;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
endpackage

// File: rtl/rr_arbiter_pick.sv
// rr_arbiter_pick: combinational round-robin picker, first request after ptr wins
module rr_arbiter_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant,
    output logic            any
);
    logic [ID_W-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = ptr;
        for (int i = 0; i < N; i++) begin
            idx = (idx == ID_W'(N - 1)) ? '0 : idx + 1'b1;
            if (!any && req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/usb_upload_arbiter.sv
// usb_upload_arbiter: packet-level round-robin mux of NUM_SRC byte producers onto the
// CDC upload stream; each frame is SYNC, source ID, payload through last.
module usb_upload_arbiter
    import usb_upload_pkg::*;
#(
    parameter int         NUM_SRC     = 4,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 1024,
    localparam int        ID_W        = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1,
    localparam int        TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC-1:0]   src_en,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC-1:0]   src_last,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_ready,
    input  logic                 usb_upload_ready,
    output logic [7:0]           usb_upload_data_out,
    output logic                 usb_upload_valid_out,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 frame_abort,
    output logic [7:0]           abort_cnt
);
    state_t          state, nxt;
    logic [ID_W-1:0] rr_ptr, pick;
    logic            pick_any, xfer, tmo, done, v_nxt;
    logic [TO_W-1:0] to_cnt, to_nxt;
    logic [7:0]      d_nxt;

    rr_arbiter_pick #(.N(NUM_SRC), .ID_W(ID_W)) u_pick (
        .req  (src_valid & src_en),
        .ptr  (rr_ptr),
        .grant(pick),
        .any  (pick_any)
    );

    assign busy      = state != IDLE;
    assign xfer      = state == PAYLOAD && usb_upload_ready && src_valid[grant_id];
    assign src_ready = (state == PAYLOAD && usb_upload_ready) ? NUM_SRC'(1) << grant_id : '0;

    always_comb begin
        nxt   = state;
        v_nxt = 1'b0;
        d_nxt = usb_upload_data_out;
        tmo   = 1'b0;
        done  = 1'b0;
        unique case (state)
            IDLE: if (pick_any) nxt = HDR0;
            HDR0: if (usb_upload_ready) begin
                nxt   = HDR1;
                v_nxt = 1'b1;
                d_nxt = SYNC_BYTE;
            end
            HDR1: if (usb_upload_ready) begin
                nxt   = PAYLOAD;
                v_nxt = 1'b1;
                d_nxt = 8'(grant_id);
            end
            PAYLOAD: if (xfer) begin
                v_nxt = 1'b1;
                d_nxt = src_data[{grant_id, 3'b000} +: 8];
                done  = src_last[grant_id];
            end else if (usb_upload_ready && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                // this stalled cycle is the one that brings the count to TIMEOUT_CYC
                tmo  = 1'b1;
                done = 1'b1;
            end
        endcase
        if (done) nxt = IDLE;
        to_nxt = (state != PAYLOAD || xfer || tmo) ? '0 : to_cnt + TO_W'(usb_upload_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            rr_ptr               <= ID_W'(NUM_SRC - 1);
            grant_id             <= '0;
            to_cnt               <= '0;
            usb_upload_valid_out <= 1'b0;
            usb_upload_data_out  <= '0;
            frame_abort          <= 1'b0;
            abort_cnt            <= '0;
        end else begin
            state                <= nxt;
            to_cnt               <= to_nxt;
            usb_upload_valid_out <= v_nxt;
            usb_upload_data_out  <= d_nxt;
            frame_abort          <= tmo;
            if (state == IDLE && pick_any) grant_id <= pick;
            if (done) rr_ptr <= grant_id;
            if (tmo && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
        end
    end
endmodule
